// File: rtl/fpu_issue_ctrl.sv
// Issue/writeback controller for a fixed-latency FP add/sub pipeline.
// Tracks destination tags in a busy scoreboard and checks pipeline alignment.
module fpu_issue_ctrl #(
   parameter int LAT  = 3,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_op,
   input  logic [4:0]      req_rs1,
   input  logic [4:0]      req_rs2,
   input  logic [4:0]      req_rd,
   input  logic [31:0]     req_a,
   input  logic [31:0]     req_b,
   output logic [31:0]     fpu_a,
   output logic [31:0]     fpu_b,
   output logic            fpu_en,
   input  logic [31:0]     fpu_c,
   input  logic            fpu_ready,
   output logic            wb_valid,
   output logic [4:0]      wb_rd,
   output logic [31:0]     wb_data,
   output logic [NREG-1:0] busy,
   output logic            err_sync
);

   localparam int CW = $clog2(LAT + 1);

   logic [LAT-1:0]  vld_q, vld_d;
   logic [4:0]      rd_q [LAT];
   logic [4:0]      rd_d [LAT];
   logic [NREG-1:0] busy_q, busy_d;
   logic            wb_valid_q, wb_valid_d;
   logic [4:0]      wb_rd_q, wb_rd_d;
   logic [31:0]     wb_data_q, wb_data_d;
   logic            err_sync_q, err_sync_d;
   logic [CW-1:0]   mask_cnt_q, mask_cnt_d;
   logic            chk_en;

   // The pipeline always subtracts, so FADD is issued as a - (-b).
   always_comb begin
      req_ready = rstn && !busy_q[req_rs1] && !busy_q[req_rs2] && !busy_q[req_rd];
      fpu_en    = req_valid && req_ready;
      fpu_a     = req_a;
      fpu_b     = req_op ? req_b : {~req_b[31], req_b[30:0]};
   end

   always_comb begin
      vld_d[0] = fpu_en;
      rd_d[0]  = req_rd;
      for (int i = 1; i < LAT; i++) begin
         vld_d[i] = vld_q[i-1];
         rd_d[i]  = rd_q[i-1];
      end

      wb_valid_d = vld_q[LAT-1];
      wb_rd_d    = rd_q[LAT-1];
      wb_data_d  = fpu_c;

      busy_d = busy_q;
      if (wb_valid_q)
         busy_d[wb_rd_q] = 1'b0;
      if (fpu_en)
         busy_d[req_rd] = 1'b1;

      // The pipeline itself is never reset, so its output is ignored until it has flushed.
      chk_en     = (mask_cnt_q == CW'(LAT));
      mask_cnt_d = chk_en ? mask_cnt_q : mask_cnt_q + CW'(1);
      err_sync_d = err_sync_q | (chk_en && (fpu_ready != vld_q[LAT-1]));
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         vld_q      <= '0;
         for (int i = 0; i < LAT; i++)
            rd_q[i] <= '0;
         busy_q     <= '0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         err_sync_q <= 1'b0;
         mask_cnt_q <= '0;
      end else begin
         vld_q      <= vld_d;
         for (int i = 0; i < LAT; i++)
            rd_q[i] <= rd_d[i];
         busy_q     <= busy_d;
         wb_valid_q <= wb_valid_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         err_sync_q <= err_sync_d;
         mask_cnt_q <= mask_cnt_d;
      end
   end

   assign wb_valid = wb_valid_q;
   assign wb_rd    = wb_rd_q;
   assign wb_data  = wb_data_q;
   assign busy     = busy_q;
   assign err_sync = err_sync_q;

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL have parameter LAT, default 3: fixed en-to-ready latency of the attached FP add/sub pipeline, in clock edges.
REQ-002 SHALL have parameter NREG, default 32: number of FP register tags tracked.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port req_valid, input, 1: request present.
REQ-006 SHALL have port req_ready, output, 1: request accepted when req_valid && req_ready at a rising edge.
REQ-007 SHALL have port req_op, input, 1: 0 = FADD (a+b), 1 = FSUB (a-b).
REQ-008 SHALL have ports req_rs1, req_rs2, req_rd, input, 5 each: source and destination tags.
REQ-009 SHALL have ports req_a, req_b, input, 32 each: IEEE-754 single operands.
REQ-010 SHALL have ports fpu_a, fpu_b, output, 32 each, and fpu_en, output, 1: drive to pipeline, which computes fpu_a - fpu_b.
REQ-011 SHALL have ports fpu_c, input, 32, and fpu_ready, input, 1: pipeline result and valid.
REQ-012 SHALL have ports wb_valid, output, 1; wb_rd, output, 5; wb_data, output, 32: registered writeback.
REQ-013 SHALL have port busy, output, NREG: scoreboard, bit i set while tag i has a result in flight.
REQ-014 SHALL have port err_sync, output, 1: sticky pipeline-misalignment flag.

Function
REQ-015 SHALL drive req_ready = rstn && !busy[rs1] && !busy[rs2] && !busy[rd], combinational; no bypass of a clearing tag.
REQ-016 SHALL drive fpu_en = req_valid && req_ready, combinational, same cycle as the accept.
REQ-017 SHALL drive fpu_a = req_a; fpu_b = req_b for FSUB and {~req_b[31], req_b[30:0]} for FADD, combinational.
REQ-018 SHALL hold in-flight {valid, rd} in a LAT-deep shift register advancing every edge; new entry = {fpu_en, req_rd}.
REQ-019 SHALL, for an accept in cycle N, see fpu_ready and fpu_c in cycle N+LAT, and register wb_valid=1, wb_rd=tag and wb_data=fpu_c for cycle N+LAT+1.
REQ-020 SHALL set busy[req_rd] at the accept edge.
REQ-021 SHALL clear busy[wb_rd] at the edge ending the wb_valid cycle; a set of one tag and a clear of a different tag at the same edge both take effect.
REQ-022 SHALL drive wb_valid low in every cycle with no completing entry; wb_rd and wb_data are don't-care then.
REQ-023 SHALL sustain one accept per cycle for independent tags; there is no backpressure on writeback.
REQ-024 SHALL take wb_data from fpu_c only, never from the shift register.
REQ-025 SHALL set err_sync when fpu_ready differs from the shift-register tail valid bit; it is cleared only by reset.
REQ-026 SHALL mask the err_sync check for LAT cycles after rstn rises, using a counter, because the pipeline is not reset.

Reset
REQ-027 SHALL, on rstn=0 at an edge, clear all shift-register valid bits, busy, wb_valid, err_sync and the mask counter; wb_rd and wb_data reset to 0.
REQ-028 SHALL hold req_ready=0 and fpu_en=0 while rstn=0.
REQ-029 SHALL drop in-flight operations when reset is asserted mid-operation: no wb_valid, busy remains clear, and later late fpu_ready pulses are masked per REQ-026.

Verification
REQ-030 SHALL be verified with FADD rd=3, a=0x3F800000, b=0x40000000 accepted in cycle 0 -> fpu_b=0xC0000000, wb_valid in cycle 4, wb_rd=3, wb_data=0x40400000.
REQ-031 SHALL be verified with FSUB rd=5, a=0x40400000, b=0x3F800000 -> fpu_b=0x3F800000, wb_data=0x40000000 in cycle 4.
REQ-032 SHALL be verified with back-to-back accepts to rd=1,2,3 in cycles 0-2 -> wb_valid in cycles 4,5,6 in order, busy[1] clear in cycle 5.
REQ-033 SHALL be verified with rd=7 issued in cycle 0 and a request with rs1=7 presented from cycle 1 -> req_ready=0 through cycle 4, accept in cycle 5.
REQ-034 SHALL be verified with rstn=0 in cycle 2 after an accept in cycle 0 -> no wb_valid, busy=0, err_sync=0 despite the late fpu_ready.
REQ-035 SHALL be verified with fpu_ready forced high in an idle, unmasked cycle -> err_sync=1 next cycle and held until reset.
